run_control_unit: RTL and testbench
===================================

RUN_CONTROL_UNIT -- requirements
Module: run_control_unit

Interface
REQ-001 Parameters: PC_WIDTH, default 16, width of the program counter; NUM_BP, default 4, number of breakpoint slots (at least 1); CNT_WIDTH, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 pc  input  PC_WIDTH  address of the instruction the processor presents this cycle.
REQ-005 instr_valid  input  1  when high and cpu_stall is low, the instruction at pc commits on the next edge.
REQ-006 cmd_valid / cmd_ready  input / output  1 / 1  command handshake; a command transfers on an edge where both are high.
REQ-007 cmd_op  input  3  0=RUN, 1=HALT, 2=STEP, 3=SET_BP, 4=CLR_BP, 5=CLR_CNT; 6 and 7 are accepted as no-ops.
REQ-008 cmd_idx  input  max(1,clog2(NUM_BP))  breakpoint slot for SET_BP and CLR_BP.
REQ-009 cmd_addr  input  PC_WIDTH  breakpoint address for SET_BP.
REQ-010 cpu_stall  output  1  processor hold; high blocks commit.
REQ-011 halted  output  1  high in the HALTED state.
REQ-012 halt_cause  output  2  0=NONE, 1=CMD, 2=BP, 3=STEP.
REQ-013 halt_bp_idx  output  max(1,clog2(NUM_BP))  slot that caused the last BP halt.
REQ-014 halt_pulse  output  1  one-cycle pulse on every entry to HALTED.
REQ-015 retired_cnt  output  CNT_WIDTH  count of committed instructions.

Function
REQ-016 The FSM shall have three states: HALTED, RUNNING, STEPPING.
REQ-017 Commit shall be defined as instr_valid=1 and cpu_stall=0.
REQ-018 In HALTED, cpu_stall shall be 1; RUN moves to RUNNING and STEP moves to STEPPING.
REQ-019 A breakpoint match shall be defined as: instr_valid=1, slot enabled, and slot address equal to pc.
REQ-020 In RUNNING, cpu_stall shall be driven combinationally high in the same cycle as a breakpoint match, so the breakpoint instruction does not commit.
REQ-021 On a breakpoint match the next state shall be HALTED with cause=BP and halt_bp_idx set to the lowest matching slot.
REQ-022 Step-over: the first instruction presented after a RUN issued from HALTED shall ignore breakpoint matches.
REQ-023 STEPPING shall hold cpu_stall low until exactly one commit, ignoring breakpoints, then enter HALTED with cause=STEP.
REQ-024 HALT in RUNNING shall enter HALTED with cause=CMD on the next edge.
REQ-025 If a HALT and a breakpoint match occur in the same cycle, cause=BP shall win.
REQ-026 RUN and STEP in RUNNING, and HALT in HALTED, shall be accepted no-ops; halt_cause shall be unchanged.
REQ-027 cmd_ready shall be 1 in HALTED and RUNNING, and 0 in STEPPING.
REQ-028 SET_BP shall write cmd_addr and set enable for slot cmd_idx; CLR_BP shall clear that slot's enable.
REQ-029 Breakpoint writes shall take effect from the cycle after acceptance, in any state.
REQ-030 An out-of-range cmd_idx (index >= NUM_BP) shall be ignored.
REQ-031 retired_cnt shall increment by 1 per commit and saturate at all-ones, never wrapping.
REQ-032 CLR_CNT shall zero retired_cnt; a CLR_CNT coincident with a commit shall yield 0.
REQ-033 Leaving HALTED shall not clear halt_cause or halt_bp_idx; they hold until the next halt.

Reset
REQ-034 While reset=0, state shall be HALTED, cpu_stall=1, halted=1, halt_cause=NONE, halt_bp_idx=0, halt_pulse=0, retired_cnt=0, all breakpoint enables=0, and the step-over flag=0.
REQ-035 A reset asserted mid-STEP or mid-RUN shall abort immediately, with outputs as in REQ-034.
REQ-036 After reset deassertion the block shall remain HALTED until a RUN or STEP is accepted.

Structure
REQ-037 The cmd_op and halt_cause encodings and the state encoding shall live in the shared processor package.
REQ-038 The breakpoint array with its comparators and priority encoder shall be one sub-module, bp_match_array, parametrised by NUM_BP and PC_WIDTH.

Verification
REQ-039 Reset, then RUN with pc sequencing 0..8 and instr_valid=1 -> retired_cnt=9 and cpu_stall=0 throughout.
REQ-040 SET_BP slot 2 to 5, then RUN -> stall in the cycle pc=5, halt_cause=BP, halt_bp_idx=2, one halt_pulse, and retired_cnt=5.
REQ-041 From the REQ-040 halt, issue RUN -> pc=5 commits without re-halting (step-over).
REQ-042 STEP three times from HALTED -> exactly one commit each, cause=STEP each time, and cmd_ready=0 while stepping.
REQ-043 HALT on the same cycle as a breakpoint match at slot 0 -> cause=BP, not CMD.
REQ-044 Preload retired_cnt near all-ones with CNT_WIDTH=4 -> saturates at 15; CLR_CNT coincident with a commit -> 0.

Source files
------------

// File: rtl/run_control_unit_pkg.sv
// Shared encodings for the run-control unit: command opcodes, halt causes, FSM states.
// Also holds the width helper used for breakpoint-slot index ports.
package run_control_unit_pkg;

  typedef enum logic [2:0] {
    OP_RUN     = 3'd0,
    OP_HALT    = 3'd1,
    OP_STEP    = 3'd2,
    OP_SET_BP  = 3'd3,
    OP_CLR_BP  = 3'd4,
    OP_CLR_CNT = 3'd5,
    OP_NOP6    = 3'd6,
    OP_NOP7    = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_CMD  = 2'd1,
    CAUSE_BP   = 2'd2,
    CAUSE_STEP = 2'd3
  } halt_cause_e;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } run_state_e;

  // Slot index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_control_unit_bp_match_array.sv
// Breakpoint slot storage with per-slot address comparators.
// Reports the lowest-numbered enabled slot whose address equals the presented pc.
module bp_match_array
  import run_control_unit_pkg::*;
#(
  parameter int unsigned NUM_BP   = 4,
  parameter int unsigned PC_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             set_en,
  input  logic                             clr_en,
  input  logic [idx_width(NUM_BP)-1:0]     idx,
  input  logic [PC_WIDTH-1:0]              addr,
  input  logic [PC_WIDTH-1:0]              pc,
  input  logic                             instr_valid,
  output logic                             hit,
  output logic [idx_width(NUM_BP)-1:0]     hit_idx
);

  localparam int unsigned IDX_W = idx_width(NUM_BP);

  logic [PC_WIDTH-1:0] bp_addr [NUM_BP];
  logic [NUM_BP-1:0]   bp_en;
  logic                idx_ok;

  assign idx_ok = 32'(idx) < NUM_BP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_en <= '0;
      for (int unsigned i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
    end else if (idx_ok) begin
      if (set_en) begin
        bp_addr[idx] <= addr;
        bp_en[idx]   <= 1'b1;
      end else if (clr_en) begin
        bp_en[idx] <= 1'b0;
      end
    end
  end

  // First match in ascending slot order wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (!hit && instr_valid && bp_en[i] && (bp_addr[i] == pc)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/run_control_unit.sv
// Debug run-control: halts, runs and single-steps the processor, handles breakpoints
// with step-over on resume, and counts retired instructions.
module run_control_unit
  import run_control_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 16,
  parameter int unsigned NUM_BP    = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PC_WIDTH-1:0]          pc,
  input  logic                         instr_valid,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [idx_width(NUM_BP)-1:0] cmd_idx,
  input  logic [PC_WIDTH-1:0]          cmd_addr,
  output logic                         cpu_stall,
  output logic                         halted,
  output logic [1:0]                   halt_cause,
  output logic [idx_width(NUM_BP)-1:0] halt_bp_idx,
  output logic                         halt_pulse,
  output logic [CNT_WIDTH-1:0]         retired_cnt
);

  localparam int unsigned IDX_W = idx_width(NUM_BP);

  run_state_e  state_q, state_d;
  halt_cause_e cause_q, cause_d;
  logic [IDX_W-1:0] bp_idx_q, bp_idx_d;
  logic        step_over_q, step_over_d;
  logic        pulse_d;
  cmd_op_e     op;
  logic        cmd_fire;
  logic        commit;
  logic        bp_hit;
  logic [IDX_W-1:0] bp_hit_idx;

  assign op          = cmd_op_e'(cmd_op);
  assign cmd_ready   = (state_q != ST_STEPPING);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign commit      = instr_valid && !cpu_stall;
  assign halted      = (state_q == ST_HALTED);
  assign halt_cause  = cause_q;
  assign halt_bp_idx = bp_idx_q;

  bp_match_array #(
    .NUM_BP   (NUM_BP),
    .PC_WIDTH (PC_WIDTH)
  ) u_bp (
    .clk         (clk),
    .reset       (reset),
    .set_en      (cmd_fire && (op == OP_SET_BP)),
    .clr_en      (cmd_fire && (op == OP_CLR_BP)),
    .idx         (cmd_idx),
    .addr        (cmd_addr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .hit         (bp_hit),
    .hit_idx     (bp_hit_idx)
  );

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    bp_idx_d    = bp_idx_q;
    step_over_d = step_over_q;
    cpu_stall   = 1'b1;
    unique case (state_q)
      ST_HALTED: begin
        step_over_d = 1'b0;
        if (cmd_fire && (op == OP_RUN)) begin
          state_d     = ST_RUNNING;
          step_over_d = 1'b1;
        end else if (cmd_fire && (op == OP_STEP)) begin
          state_d = ST_STEPPING;
        end
      end
      ST_RUNNING: begin
        // The step-over flag masks only the first presented instruction after resume.
        cpu_stall = bp_hit && !step_over_q;
        if (instr_valid) step_over_d = 1'b0;
        if (bp_hit && !step_over_q) begin
          state_d  = ST_HALTED;
          cause_d  = CAUSE_BP;
          bp_idx_d = bp_hit_idx;
        end else if (cmd_fire && (op == OP_HALT)) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_CMD;
        end
      end
      ST_STEPPING: begin
        cpu_stall = 1'b0;
        if (instr_valid) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_STEP;
        end
      end
      default: state_d = ST_HALTED;
    endcase
    pulse_d = (state_d == ST_HALTED) && (state_q != ST_HALTED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HALTED;
      cause_q     <= CAUSE_NONE;
      bp_idx_q    <= '0;
      step_over_q <= 1'b0;
      halt_pulse  <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      bp_idx_q    <= bp_idx_d;
      step_over_q <= step_over_d;
      halt_pulse  <= pulse_d;
      if (cmd_fire && (op == OP_CLR_CNT)) begin
        retired_cnt <= '0;
      end else if (commit && (retired_cnt != '1)) begin
        retired_cnt <= retired_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_run_control_unit.sv
// Directed bench for run_control_unit: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_run_control_unit;

  localparam int unsigned PW = 16;
  localparam int unsigned NB = 3;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic [PW-1:0] pc;
  logic          instr_valid;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [1:0]    cmd_idx;
  logic [PW-1:0] cmd_addr;
  logic          cpu_stall;
  logic          halted;
  logic [1:0]    halt_cause;
  logic [1:0]    halt_bp_idx;
  logic          halt_pulse;
  logic [CW-1:0] retired_cnt;

  run_control_unit #(
    .PC_WIDTH  (PW),
    .NUM_BP    (NB),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instr_valid (instr_valid),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_idx     (cmd_idx),
    .cmd_addr    (cmd_addr),
    .cpu_stall   (cpu_stall),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .halt_bp_idx (halt_bp_idx),
    .halt_pulse  (halt_pulse),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {S_STALL, S_HALTED, S_CAUSE, S_BPIDX, S_PULSE, S_CNT, S_READY} sig_e;
  typedef struct {
    string name;
    sig_e  sig;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic ex(input string nm, input sig_e s, input int v);
    exp_t e;
    e.name = nm;
    e.sig  = s;
    e.val  = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        S_STALL:  act = int'(cpu_stall);
        S_HALTED: act = int'(halted);
        S_CAUSE:  act = int'(halt_cause);
        S_BPIDX:  act = int'(halt_bp_idx);
        S_PULSE:  act = int'(halt_pulse);
        S_CNT:    act = int'(retired_cnt);
        default:  act = int'(cmd_ready);
      endcase
      n_total++;
      if (act == e.val) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", e.name, act, e.val, $time);
    end
  end

  task automatic drv(input logic iv, input logic [PW-1:0] p, input logic cv, input logic [2:0] op);
    instr_valid = iv;
    pc          = p;
    cmd_valid   = cv;
    cmd_op      = op;
  endtask

  task automatic drv_bp(input logic [2:0] op, input logic [1:0] idx, input logic [PW-1:0] a);
    instr_valid = 1'b0;
    pc          = '0;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_idx     = idx;
    cmd_addr    = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drv(1'b0, '0, 1'b0, 3'd0);
    cmd_idx  = '0;
    cmd_addr = '0;
    ex("rst_stall", S_STALL, 1);
    ex("rst_halted", S_HALTED, 1);
    ex("rst_cause", S_CAUSE, 0);
    ex("rst_bpidx", S_BPIDX, 0);
    ex("rst_pulse", S_PULSE, 0);
    ex("rst_cnt", S_CNT, 0);
    ex("rst_ready", S_READY, 1);
    tick();
    tick();
    reset = 1'b1;

    // Free run over pc 0..8
    drv(1'b0, '0, 1'b1, 3'd0);
    ex("t1_pre_halted", S_HALTED, 1);
    tick();
    for (int p = 0; p < 9; p++) begin
      drv(1'b1, 16'(p), 1'b0, 3'd0);
      ex("t1_stall", S_STALL, 0);
      ex("t1_cnt", S_CNT, p);
      tick();
    end
    drv(1'b0, '0, 1'b1, 3'd5);
    ex("t1_cnt9", S_CNT, 9);
    ex("t1_running", S_HALTED, 0);
    tick();
    drv(1'b0, '0, 1'b0, 3'd0);
    ex("t1_clr_cnt", S_CNT, 0);
    tick();

    // Breakpoint at slot 2 = 5; slot 3 is out of range for NUM_BP=3
    drv_bp(3'd3, 2'd2, 16'd5);
    tick();
    drv_bp(3'd3, 2'd3, 16'd2);
    tick();
    drv(1'b0, '0, 1'b1, 3'd1);
    ex("t2_halt_cmd_running", S_HALTED, 0);
    tick();
    drv(1'b0, '0, 1'b1, 3'd0);
    ex("t2_cmd_halted", S_HALTED, 1);
    ex("t2_cmd_cause", S_CAUSE, 1);
    ex("t2_cmd_pulse", S_PULSE, 1);
    tick();
    for (int p = 0; p < 5; p++) begin
      drv(1'b1, 16'(p), 1'b0, 3'd0);
      ex("t2_stall", S_STALL, 0);
      ex("t2_cnt", S_CNT, p);
      tick();
    end
    drv(1'b1, 16'd5, 1'b0, 3'd0);
    ex("t2_bp_stall", S_STALL, 1);
    ex("t2_bp_not_yet_halted", S_HALTED, 0);
    ex("t2_bp_cnt", S_CNT, 5);
    tick();
    drv(1'b1, 16'd5, 1'b1, 3'd0);
    ex("t2_bp_halted", S_HALTED, 1);
    ex("t2_bp_cause", S_CAUSE, 2);
    ex("t2_bp_idx", S_BPIDX, 2);
    ex("t2_bp_pulse", S_PULSE, 1);
    ex("t2_bp_cnt_hold", S_CNT, 5);
    tick();

    // Resume over the breakpoint instruction
    drv(1'b1, 16'd5, 1'b0, 3'd0);
    ex("t3_stepover_stall", S_STALL, 0);
    ex("t3_running", S_HALTED, 0);
    ex("t3_pulse_once", S_PULSE, 0);
    ex("t3_cnt", S_CNT, 5);
    ex("t3_cause_kept", S_CAUSE, 2);
    tick();
    drv(1'b1, 16'd6, 1'b0, 3'd0);
    ex("t3_stall6", S_STALL, 0);
    ex("t3_cnt6", S_CNT, 6);
    tick();
    drv(1'b0, '0, 1'b1, 3'd1);
    ex("t3_cnt7", S_CNT, 7);
    tick();
    drv(1'b0, '0, 1'b0, 3'd0);
    ex("t3_halted", S_HALTED, 1);
    ex("t3_cause_cmd", S_CAUSE, 1);
    ex("t3_cnt_hold", S_CNT, 7);
    tick();

    // Three single steps, first one across the pc=5 breakpoint
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, '0, 1'b1, 3'd2);
      ex("t4_pre_halted", S_HALTED, 1);
      ex("t4_pre_ready", S_READY, 1);
      tick();
      drv(1'b0, '0, 1'b1, 3'd0);
      ex("t4_ready_low", S_READY, 0);
      ex("t4_stall_low", S_STALL, 0);
      ex("t4_stepping", S_HALTED, 0);
      tick();
      drv(1'b1, 16'(5 + k), 1'b0, 3'd0);
      ex("t4_commit_stall", S_STALL, 0);
      ex("t4_cnt_before", S_CNT, 7 + k);
      tick();
      drv(1'b0, '0, 1'b0, 3'd0);
      ex("t4_halted", S_HALTED, 1);
      ex("t4_cause_step", S_CAUSE, 3);
      ex("t4_pulse", S_PULSE, 1);
      ex("t4_cnt_after", S_CNT, 8 + k);
      tick();
    end

    // HALT coincident with breakpoint; two slots match, lowest wins
    drv_bp(3'd3, 2'd0, 16'h20);
    tick();
    drv_bp(3'd3, 2'd1, 16'h20);
    tick();
    drv(1'b0, '0, 1'b1, 3'd0);
    tick();
    drv(1'b1, 16'h10, 1'b0, 3'd0);
    ex("t5_cnt10", S_CNT, 10);
    tick();
    drv(1'b1, 16'h20, 1'b1, 3'd1);
    ex("t5_bp_halt_stall", S_STALL, 1);
    ex("t5_cnt11", S_CNT, 11);
    tick();
    drv(1'b0, '0, 1'b0, 3'd0);
    ex("t5_halted", S_HALTED, 1);
    ex("t5_cause_bp", S_CAUSE, 2);
    ex("t5_bpidx0", S_BPIDX, 0);
    ex("t5_pulse", S_PULSE, 1);
    ex("t5_cnt_hold", S_CNT, 11);
    tick();
    drv_bp(3'd4, 2'd0, '0);
    tick();
    drv(1'b0, '0, 1'b1, 3'd0);
    tick();
    drv(1'b1, 16'h20, 1'b0, 3'd0);
    ex("t5_stepover_stall", S_STALL, 0);
    ex("t5_cnt11b", S_CNT, 11);
    tick();
    drv(1'b1, 16'h11, 1'b0, 3'd0);
    ex("t5_cnt12", S_CNT, 12);
    tick();
    drv(1'b1, 16'h20, 1'b0, 3'd0);
    ex("t5_slot1_stall", S_STALL, 1);
    ex("t5_cnt13", S_CNT, 13);
    tick();
    drv(1'b0, '0, 1'b0, 3'd0);
    ex("t5_slot1_halted", S_HALTED, 1);
    ex("t5_slot1_cause", S_CAUSE, 2);
    ex("t5_bpidx1", S_BPIDX, 1);
    ex("t5_slot1_cnt", S_CNT, 13);
    tick();

    // Counter saturation, STEP no-op while running, CLR_CNT racing a commit
    drv_bp(3'd4, 2'd1, '0);
    tick();
    drv_bp(3'd4, 2'd2, '0);
    tick();
    drv(1'b0, '0, 1'b1, 3'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 16'(64 + k), (k == 1), 3'd2);
      ex("t6_cnt", S_CNT, (k < 2) ? 13 + k : 15);
      ex("t6_running", S_HALTED, 0);
      ex("t6_cause_kept", S_CAUSE, 2);
      tick();
    end
    drv(1'b1, 16'h50, 1'b1, 3'd5);
    ex("t6_sat", S_CNT, 15);
    tick();
    drv(1'b1, 16'h51, 1'b0, 3'd0);
    ex("t6_clr_with_commit", S_CNT, 0);
    tick();
    drv(1'b0, '0, 1'b0, 3'd0);
    ex("t6_cnt_after_clr", S_CNT, 1);
    tick();

    // Asynchronous reset while running
    drv(1'b1, 16'h52, 1'b0, 3'd0);
    reset = 1'b0;
    ex("t7_rst_halted", S_HALTED, 1);
    ex("t7_rst_stall", S_STALL, 1);
    ex("t7_rst_cause", S_CAUSE, 0);
    ex("t7_rst_bpidx", S_BPIDX, 0);
    ex("t7_rst_pulse", S_PULSE, 0);
    ex("t7_rst_cnt", S_CNT, 0);
    ex("t7_rst_ready", S_READY, 1);
    tick();
    reset = 1'b1;
    drv(1'b1, 16'h53, 1'b0, 3'd0);
    ex("t7_stay_halted", S_HALTED, 1);
    ex("t7_stay_stall", S_STALL, 1);
    ex("t7_stay_cnt", S_CNT, 0);
    tick();
    ex("t7_stay_halted2", S_HALTED, 1);
    ex("t7_stay_cnt2", S_CNT, 0);
    tick();
    drv(1'b0, '0, 1'b0, 3'd0);
    tick();

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
